// File: rtl/mdu_pkg.sv
// Shared definitions for the MDU sequencer: op encodings, FSM states, default width.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } mdu_state_e;

    function automatic logic op_is_iter(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration of the MDU datapath: shift-add multiply or restoring divide.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] opnd_o,
    output logic [WIDTH-1:0]   mplier_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Divide keeps {remainder, dividend/quotient} in acc; divisor sits in opnd low half.
    assign rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, opnd_i[WIDTH-1:0]};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        acc_o    = acc_i;
        opnd_o   = opnd_i;
        mplier_o = mplier_i;
        if (is_div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mplier_i[0]) begin
                acc_o = acc_i + opnd_i;
            end
            opnd_o   = opnd_i << 1;
            mplier_o = mplier_i >> 1;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/DIV sequencer owning HI/LO; MDU_EARLY_EXIT_EN enables early multiply exit
// once the remaining multiplier bits are zero.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_e,
    input  logic [2:0]       op_e,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             hazard_d,
    input  logic             kill_e,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               res_neg_q, res_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               done_q, done_d;

    mdu_op_e            op;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc, step_opnd;
    logic [WIDTH-1:0]   step_mplier;
    logic               calc_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops iterate on magnitudes; signs are reapplied in FIXUP.
    assign op     = mdu_op_e'(op_e);
    assign sign_a = op_is_signed(op) & srca_e[WIDTH-1];
    assign sign_b = op_is_signed(op) & srcb_e[WIDTH-1];
    assign mag_a  = sign_a ? -srca_e : srca_e;
    assign mag_b  = sign_b ? -srcb_e : srcb_e;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .mplier_i (mplier_q),
        .acc_o    (step_acc),
        .opnd_o   (step_opnd),
        .mplier_o (step_mplier)
    );

`ifdef MDU_EARLY_EXIT_EN
    assign calc_last = (counter_q == LAST_CNT) || (!is_div_q && (step_mplier == '0));
`else
    assign calc_last = (counter_q == LAST_CNT);
`endif

    assign prod_fix = res_neg_q ? -acc_q : acc_q;
    assign quo_fix  = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_e && !kill_e) begin
                    if (op_is_iter(op)) begin
                        state_d   = CALC;
                        counter_d = '0;
                        is_div_d  = op_is_div(op);
                        res_neg_d = sign_a ^ sign_b;
                        rem_neg_d = sign_a;
                        if (op_is_div(op)) begin
                            acc_d    = {{WIDTH{1'b0}}, mag_a};
                            opnd_d   = {{WIDTH{1'b0}}, mag_b};
                            mplier_d = '0;
                        end else begin
                            acc_d    = '0;
                            opnd_d   = {{WIDTH{1'b0}}, mag_a};
                            mplier_d = mag_b;
                        end
                    end else if (op == OP_MTHI) begin
                        hi_d = srca_e;
                    end else if (op == OP_MTLO) begin
                        lo_d = srca_e;
                    end
                end
            end
            CALC: begin
                if (kill_e) begin
                    state_d = IDLE;
                end else begin
                    acc_d     = step_acc;
                    opnd_d    = step_opnd;
                    mplier_d  = step_mplier;
                    counter_d = counter_q + CNT_W'(1);
                    if (calc_last) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!kill_e) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            mplier_q  <= mplier_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            done_q    <= done_d;
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign stall_o = busy_o & hazard_d;
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed ops push expected HI/LO/latency, a monitor checks on done_o.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_e;
    logic [2:0]   op_e;
    logic [W-1:0] srca_e, srcb_e;
    logic         hazard_d, kill_e;
    logic         busy_o, stall_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_e  (start_e),
        .op_e     (op_e),
        .srca_e   (srca_e),
        .srcb_e   (srcb_e),
        .hazard_d (hazard_d),
        .kill_e   (kill_e),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           issue_cyc;
        int           lat;
        int           tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   tag_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input mdu_op_e op, input logic [W-1:0] b);
        int it;
        logic [W-1:0] mag;
        it = 1;
        mag = b;
`ifdef MDU_EARLY_EXIT_EN
        if (op == OP_MULT || op == OP_MULTU) begin
            mag = (op == OP_MULT && b[W-1]) ? -b : b;
            for (int i = 0; i < W; i++) if (mag[i]) it = i + 1;
            return it + 1;
        end
`endif
        return W + 1 + (it - 1) + int'(mag & '0);
    endfunction

    // Monitor: every done_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1, want no pending op (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("op%0d_hi", e.tag), 64'(hi_o), 64'(e.hi));
                check($sformatf("op%0d_lo", e.tag), 64'(lo_o), 64'(e.lo));
                check($sformatf("op%0d_latency", e.tag), 64'(cyc - e.issue_cyc - 1), 64'(e.lat));
                check($sformatf("op%0d_stall_in_done", e.tag), 64'(stall_o), 64'(0));
            end
        end
    end

    task automatic issue(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic kill, input logic push,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        @(negedge clk);
        check("idle_at_issue", 64'(busy_o), 64'(0));
        start_e = 1'b1;
        op_e    = op;
        srca_e  = a;
        srcb_e  = b;
        kill_e  = kill;
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.issue_cyc = cyc;
            e.lat = exp_lat(op, b);
            e.tag = tag_n;
            tag_n++;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start_e = 1'b0;
        kill_e  = 1'b0;
    endtask

    task automatic run_op(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hz, input logic [W-1:0] eh, input logic [W-1:0] el);
        int nb, ns, lat;
        lat = exp_lat(op, b);
        hazard_d = hz;
        issue(op, a, b, 1'b0, 1'b1, eh, el);
        nb = 0;
        ns = 0;
        while (busy_o && nb < 200) begin
            nb++;
            if (stall_o) ns++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(nb), 64'(lat));
        check("stall_cycles", 64'(ns), 64'(hz ? lat : 0));
        hazard_d = 1'b0;
    endtask

    initial begin
        int d0, n;
        rst_n = 1'b0;
        start_e = 1'b0;
        op_e = '0;
        srca_e = '0;
        srcb_e = '0;
        hazard_d = 1'b0;
        kill_e = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi_o), 64'(0));
        check("rst_lo", 64'(lo_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        rst_n = 1'b1;

        // MTHI/MTLO single-cycle writes.
        issue(OP_MTHI, 32'h0000ABCD, '0, 1'b0, 1'b0, '0, '0);
        check("mthi_hi", 64'(hi_o), 64'h0000ABCD);
        check("mthi_lo", 64'(lo_o), 64'(0));
        check("mthi_busy", 64'(busy_o), 64'(0));

        // Iterative ops with hand-computed results.
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000);
        run_op(OP_DIVU,  32'h00000007, 32'h00000000, 1'b1, 32'h00000007, 32'hFFFFFFFF);
        run_op(OP_DIVU,  32'd100,      32'd7,        1'b0, 32'd2,        32'd14);
        run_op(OP_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'd1,        32'hFFFFFFFD);
        run_op(OP_MULTU, 32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780);
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
        run_op(OP_MULTU, 32'd5,        32'd0,        1'b0, 32'd0,        32'd0);

        // Kill mid-CALC leaves HI/LO untouched and produces no done_o.
        issue(OP_MTHI, 32'h11, '0, 1'b0, 1'b0, '0, '0);
        issue(OP_MTLO, 32'h22, '0, 1'b0, 1'b0, '0, '0);
        check("preset_hi", 64'(hi_o), 64'h11);
        check("preset_lo", 64'(lo_o), 64'h22);
        d0 = done_cnt;
        issue(OP_MULT, 32'h11, 32'h7FFFFFFF, 1'b0, 1'b0, '0, '0);
        repeat (8) @(negedge clk);
        kill_e = 1'b1;
        @(negedge clk);
        kill_e = 1'b0;
        check("kill_busy", 64'(busy_o), 64'(0));
        check("kill_hi", 64'(hi_o), 64'h11);
        check("kill_lo", 64'(lo_o), 64'h22);
        repeat (40) @(negedge clk);
        check("kill_no_done", 64'(done_cnt), 64'(d0));

        // start_e together with kill_e is ignored.
        issue(OP_MULTU, 32'd3, 32'd4, 1'b1, 1'b0, '0, '0);
        check("start_kill_busy", 64'(busy_o), 64'(0));
        repeat (40) @(negedge clk);
        check("start_kill_no_done", 64'(done_cnt), 64'(d0));
        check("start_kill_lo", 64'(lo_o), 64'h22);

        // Asynchronous reset in the middle of an operation.
        hazard_d = 1'b1;
        issue(OP_MULT, 32'h11, 32'h7FFFFFFF, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi_o), 64'(0));
        check("arst_lo", 64'(lo_o), 64'(0));
        check("arst_busy", 64'(busy_o), 64'(0));
        check("arst_stall", 64'(stall_o), 64'(0));
        check("arst_done", 64'(done_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        hazard_d = 1'b0;
        repeat (40) @(negedge clk);
        check("arst_no_done", 64'(done_cnt), 64'(d0));

        // Drain anything still outstanding, bounded.
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Iterative multiply/divide controller for the 5-stage MIPS pipeline, driven from the EX stage.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the HI/LO registers.
- Handles MTHI/MTLO as single-cycle writes.
- Raises a stall to the hazard path while a decode-stage instruction depends on an in-flight operation.

Parameters:
WIDTH, 32, operand/HI/LO width; must be even and >= 8.
CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset
start_e  in  1  EX stage holds a valid MDU instruction this cycle
op_e  in  3  mdu_pkg op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO
srca_e  in  WIDTH  rs operand
srcb_e  in  WIDTH  rt operand
hazard_d  in  1  decode holds MFHI/MFLO or any MDU op
kill_e  in  1  abort in-flight operation (exception/flush)
busy_o  out  1  state != IDLE
stall_o  out  1  busy_o & hazard_d
done_o  out  1  one-cycle pulse, HI/LO just updated by an iterative op
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset:
  - One clock (clk); reset rst_n is asynchronous, active-low.
  - Asserting rst_n low forces, immediately: state=IDLE, hi_o=0, lo_o=0, done_o=0, busy_o=0, stall_o=0, counter=0.
  - Reset asserted mid-operation discards the operation.
- FSM states: IDLE, CALC, FIXUP.
- IDLE:
  - start_e & MULT/MULTU/DIV/DIVU & !kill_e: latch |operands| (signed ops take the absolute value), record result signs, counter=0, go to CALC.
  - start_e & MTHI/MTLO: write srca_e to HI/LO at this edge; stay IDLE; no done_o.
  - kill_e in the same cycle as start_e: start is ignored.
- CALC:
  - One radix-2 iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Leave for FIXUP on the edge where counter==WIDTH-1.
- FIXUP:
  - Apply signs. Product is negated if the operand signs differ. Quotient is negated if the signs differ. Remainder takes the dividend's sign.
  - Write HI/LO, set done_o=1 for one cycle, go to IDLE.
- Latency: start sampled at edge 0; new HI/LO and done_o visible after edge WIDTH+1 (33 for WIDTH=32). busy_o is high for WIDTH+1 cycles.
- HI/LO results:
  - Multiply: {HI,LO} = 2*WIDTH-bit product.
  - Divide: LO=quotient, HI=remainder.
- Divide by zero: completes at normal latency with LO=all-ones and HI=dividend (before sign handling; for unsigned, HI=srca_e). DIV with divisor 0 uses the same raw values; no trap.
- Signed overflow DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- kill_e in CALC or FIXUP: go to IDLE next edge. HI/LO unchanged, no done_o.
- start_e while busy_o: ignored. The pipeline must not issue while stalled, and the bench checks that this never occurs.
- stall_o is combinational from registered state. It is low in the done_o cycle because the state is then IDLE.

Optional Feature:
Macro MDU_EARLY_EXIT_EN.
- Defined: for multiply only, CALC goes to FIXUP on any edge where the remaining unshifted multiplier bits are all zero. Minimum latency is 2 cycles (multiplier 0). Results are identical to the full iteration.
- Undefined: fixed WIDTH+1 latency for all iterative ops. Divide is always fixed-latency.

Decomposition:
- mdu_pkg: op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5), state enum (IDLE/CALC/FIXUP), and the default width constant.
- Sub-module mdu_iter_step: purely combinational single-iteration datapath.
  - Inputs: partial remainder/product and operand.
  - Outputs: next partial remainder/product.
  - mdu_sequencer holds all registers and the FSM.

Test Plan:
1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy_o high 33 cycles; done_o after edge 33; hi_o=0xFFFFFFFE, lo_o=0x00000001.
2. MULT -3*7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/-1 -> lo_o=0x80000000, hi_o=0.
3. DIVU 7/0 -> lo_o=0xFFFFFFFF, hi_o=0x00000007, normal latency, done_o pulses once.
4. hazard_d held high across a DIVU -> stall_o high cycles 1..33, low in the done_o cycle. hazard_d low -> stall_o never high.
5. MULT started with HI=0x11, LO=0x22. Cases and required results:
   - kill_e at cycle 10 -> IDLE next edge, HI/LO still 0x11/0x22, no done_o.
   - rst_n low at cycle 5 -> all outputs 0 immediately.
6. MTHI 0xABCD in IDLE -> hi_o=0xABCD after one edge, busy_o stays 0. With MDU_EARLY_EXIT_EN defined, MULTU 5*0 -> done_o after edge 2, HI=LO=0.
